// File: rtl/irq_pending_latch.sv
// Request-capture stage: edge-detects raw request lines into sticky pending bits with per-line overflow.
// Build option IRQ_SYNC_EN inserts a 2-flop synchroniser per line ahead of the edge detector.
module irq_pending_latch #(
  parameter int unsigned N_REQ = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_in,
  input  logic [N_REQ-1:0] mask,
  input  logic             ack_valid,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             ovf_clr,
  output logic [N_REQ-1:0] pend,
  output logic             pend_any,
  output logic [N_REQ-1:0] ovf
);

  logic [N_REQ-1:0] s;
  logic [N_REQ-1:0] s_d;
  logic [N_REQ-1:0] edge_det;
  logic [N_REQ-1:0] set_vec;
  logic [N_REQ-1:0] clr_vec;
  logic [N_REQ-1:0] pend_nxt;
  logic [N_REQ-1:0] ovf_nxt;

`ifdef IRQ_SYNC_EN
  logic [N_REQ-1:0] sync1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= req_in;
      s     <= sync1;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s <= '0;
    else     s <= req_in;
  end
`endif

  // History resets low, so a line held high through reset produces one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_d <= '0;
    else     s_d <= s;
  end

  always_comb begin
    clr_vec  = '0;
    edge_det = s & ~s_d;
    set_vec  = edge_det & ~mask;
    // Only in-range indices can match, so out-of-range acks fall through untouched.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      clr_vec[i] = ack_valid && (ack_idx == IDX_W'(i));
    end
    pend_nxt = (pend & ~clr_vec) | set_vec;
    ovf_nxt  = (ovf_clr ? '0 : ovf) | (set_vec & pend & ~clr_vec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      ovf      <= '0;
      pend_any <= 1'b0;
    end else begin
      pend     <= pend_nxt;
      ovf      <= ovf_nxt;
      pend_any <= |pend_nxt;
    end
  end

endmodule
